// File: rtl/imm_extend_ctrl.sv
// ID-stage immediate-extension controller: decodes the opcode into an extension
// mode, forms the extended immediate and hands it to EX through a 2-entry skid buffer.
module imm_extend_ctrl #(
    parameter int IMM_W      = 16,
    parameter int DATA_W     = 32,
    parameter bit SLTIU_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       Instruction,
    input  logic              InValid,
    output logic              InReady,
    input  logic              Flush,
    input  logic              OutReady,
    output logic              OutValid,
    output logic [DATA_W-1:0] ExtImmediate,
    output logic [1:0]        ExtMode,
    output logic              IllegalOp
);

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_SIGN = 2'b01;
    localparam logic [1:0] MODE_ZERO = 2'b10;
    localparam logic [1:0] MODE_LUI  = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef struct packed {
        logic [DATA_W-1:0] imm;
        logic [1:0]        mode;
        logic              illegal;
    } entry_t;

    logic [5:0]       op;
    logic [IMM_W-1:0] imm_field;
    entry_t           dec;

    entry_t out_q, out_d;
    logic   out_valid_q, out_valid_d;
    entry_t skid_q, skid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;

    logic   in_fire;
    logic   out_fire;

    assign op        = Instruction[31:26];
    assign imm_field = Instruction[IMM_W-1:0];

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dec.mode    = MODE_NONE;
        dec.illegal = 1'b0;
        unique case (op)
            OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
            OP_SLTI, OP_LW, OP_SW:           dec.mode = MODE_SIGN;
            OP_SLTIU:                        dec.mode = SLTIU_ZERO ? MODE_ZERO : MODE_SIGN;
            OP_ANDI, OP_ORI, OP_XORI:        dec.mode = MODE_ZERO;
            OP_LUI:                          dec.mode = MODE_LUI;
            OP_RTYPE, OP_J, OP_JAL:          dec.mode = MODE_NONE;
            default:                         dec.illegal = 1'b1;
        endcase
    end

    always_comb begin
        dec.imm = '0;
        unique case (dec.mode)
            MODE_SIGN: dec.imm = {{(DATA_W-IMM_W){imm_field[IMM_W-1]}}, imm_field};
            MODE_ZERO: dec.imm = {{(DATA_W-IMM_W){1'b0}}, imm_field};
            MODE_LUI:  dec.imm[2*IMM_W-1:IMM_W] = imm_field;
            default:   dec.imm = '0;
        endcase
    end

    assign in_fire  = InValid & in_ready_q;
    assign out_fire = out_valid_q & OutReady;

    // Entry 0 is free at the edge when it is empty or being consumed; the skid
    // entry always drains first so order stays FIFO.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (Flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_fire || !out_valid_q) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // NOTE: skid payload is not reset; it is only ever read while skid_valid_q is set.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign InReady      = in_ready_q;
    assign OutValid     = out_valid_q;
    assign ExtImmediate = out_q.imm;
    assign ExtMode      = out_q.mode;
    assign IllegalOp    = out_q.illegal;

endmodule

// File: tb/tb_imm_extend_ctrl.sv
// Directed bench for imm_extend_ctrl: scoreboard of expected outputs pushed on
// accept and popped on each EX transfer, plus directed handshake checks.
module tb_imm_extend_ctrl;

    typedef struct packed {
        logic [31:0] imm;
        logic [1:0]  mode;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Instruction;
    logic        InValid, Flush, OutReady;
    logic        InReady, OutValid, IllegalOp;
    logic [31:0] ExtImmediate;
    logic [1:0]  ExtMode;

    logic        z_in_ready, z_out_valid, z_illegal;
    logic [31:0] z_imm;
    logic [1:0]  z_mode;

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    imm_extend_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .Instruction(Instruction), .InValid(InValid),
        .InReady(InReady), .Flush(Flush), .OutReady(OutReady), .OutValid(OutValid),
        .ExtImmediate(ExtImmediate), .ExtMode(ExtMode), .IllegalOp(IllegalOp)
    );

    imm_extend_ctrl #(.SLTIU_ZERO(1'b1)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .Instruction(Instruction), .InValid(InValid),
        .InReady(z_in_ready), .Flush(Flush), .OutReady(OutReady), .OutValid(z_out_valid),
        .ExtImmediate(z_imm), .ExtMode(z_mode), .IllegalOp(z_illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mk(input logic [5:0] opc, input logic [15:0] imm);
        return {opc, 10'h000, imm};
    endfunction

    // Reference decode for the default build (sltiu sign-extends).
    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t e;
        logic [15:0] imm;
        imm = ins[15:0];
        e   = '0;
        case (ins[31:26])
            6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
                e.mode = 2'b01;
                e.imm  = {{16{imm[15]}}, imm};
            end
            6'h0C, 6'h0D, 6'h0E: begin
                e.mode = 2'b10;
                e.imm  = {16'h0000, imm};
            end
            6'h0F: begin
                e.mode = 2'b11;
                e.imm  = {imm, 16'h0000};
            end
            6'h00, 6'h02, 6'h03: e.mode = 2'b00;
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    // Monitor on the falling edge: retire the transfer happening at the next
    // rising edge first, then record a newly accepted instruction.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (OutValid && OutReady) begin
                exp_t e;
                n_out++;
                check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("sb_imm", 64'(ExtImmediate), 64'(e.imm));
                    check("sb_mode", 64'(ExtMode), 64'(e.mode));
                    check("sb_illegal", 64'(IllegalOp), 64'(e.illegal));
                end
            end
            if (Flush) sb_q.delete();
            else if (InValid && InReady) sb_q.push_back(ref_decode(Instruction));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic ordy, input logic fl);
        Instruction = ins;
        InValid     = v;
        OutReady    = ordy;
        Flush       = fl;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mode_ins [5];
        int          out_base;

        rst_n = 1'b0;
        drive(32'h0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        check("rst_out_valid", 64'(OutValid), 64'd0);
        check("rst_imm", 64'(ExtImmediate), 64'd0);
        check("rst_mode", 64'(ExtMode), 64'd0);
        check("rst_illegal", 64'(IllegalOp), 64'd0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 64'(InReady), 64'd1);

        // One instruction per mode, each expected exactly one cycle after accept.
        mode_ins[0] = mk(6'h08, 16'hFFFF);
        mode_ins[1] = mk(6'h0D, 16'hFFFF);
        mode_ins[2] = mk(6'h0F, 16'h1234);
        mode_ins[3] = 32'h0128_4020;
        mode_ins[4] = mk(6'h3F, 16'h5A5A);
        for (int i = 0; i < 5; i++) begin
            drive(mode_ins[i], 1'b1, 1'b1, 1'b0);
            step();
            drive(32'h0, 1'b0, 1'b1, 1'b0);
            check("mode_latency", 64'(OutValid), 64'd1);
            step();
            check("mode_drained", 64'(OutValid), 64'd0);
        end

        // Backpressure: two accepts fill both entries, third is held off.
        drive(mk(6'h23, 16'h0004), 1'b1, 1'b0, 1'b0);
        step();
        drive(mk(6'h2B, 16'h8000), 1'b1, 1'b0, 1'b0);
        step();
        check("bp_in_ready_low", 64'(InReady), 64'd0);
        drive(mk(6'h0C, 16'h00FF), 1'b1, 1'b0, 1'b0);
        step();
        step();
        check("bp_hold_imm", 64'(ExtImmediate), 64'h0000_0004);
        check("bp_hold_in_ready", 64'(InReady), 64'd0);
        out_base = n_out;
        OutReady = 1'b1;
        step();
        check("bp_second_imm", 64'(ExtImmediate), 64'hFFFF_8000);
        step();
        InValid = 1'b0;
        check("bp_third_imm", 64'(ExtImmediate), 64'h0000_00FF);
        step();
        step();
        check("bp_out_count", 64'(n_out - out_base), 64'd3);
        check("bp_sb_empty", 64'(sb_q.size()), 64'd0);

        // Flush with both entries full and input pending.
        drive(mk(6'h09, 16'h0011), 1'b1, 1'b0, 1'b0);
        step();
        drive(mk(6'h09, 16'h0022), 1'b1, 1'b0, 1'b0);
        step();
        drive(mk(6'h09, 16'h0033), 1'b1, 1'b0, 1'b1);
        step();
        drive(32'h0, 1'b0, 1'b1, 1'b0);
        check("flush_out_valid", 64'(OutValid), 64'd0);
        check("flush_in_ready", 64'(InReady), 64'd1);
        // Flush in the same cycle as an accept drops that input.
        drive(mk(6'h0E, 16'h0044), 1'b1, 1'b1, 1'b1);
        step();
        drive(32'h0, 1'b0, 1'b1, 1'b0);
        check("flush_accept_drop", 64'(OutValid), 64'd0);
        step();
        check("flush_stays_empty", 64'(OutValid), 64'd0);

        // Back-to-back throughput.
        out_base = n_out;
        for (int i = 0; i < 8; i++) begin
            drive(mk((i % 2 == 0) ? 6'h09 : 6'h0D, 16'($urandom)), 1'b1, 1'b1, 1'b0);
            step();
            check("b2b_out_valid", 64'(OutValid), 64'd1);
        end
        drive(32'h0, 1'b0, 1'b1, 1'b0);
        step();
        check("b2b_out_count", 64'(n_out - out_base), 64'd8);

        // sltiu in both builds.
        drive(mk(6'h0B, 16'h8000), 1'b1, 1'b1, 1'b0);
        step();
        drive(32'h0, 1'b0, 1'b1, 1'b0);
        check("sltiu_def_imm", 64'(ExtImmediate), 64'hFFFF_8000);
        check("sltiu_def_mode", 64'(ExtMode), 64'd1);
        check("sltiu_z_valid", 64'(z_out_valid), 64'd1);
        check("sltiu_z_imm", 64'(z_imm), 64'h0000_8000);
        check("sltiu_z_mode", 64'(z_mode), 64'd2);
        check("sltiu_z_illegal", 64'(z_illegal), 64'd0);
        step();
        step();
        check("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
